// File: rtl/rnd_pkg.sv
// Shared rounding-mode encodings and lane-result field widths for the
// power-of-two rounder.
package rnd_pkg;

  typedef logic [1:0] rnd_mode_t;

  localparam rnd_mode_t RND_NEAREST = 2'b00;
  localparam rnd_mode_t RND_FLOOR   = 2'b01;
  localparam rnd_mode_t RND_CEIL    = 2'b10;
  localparam rnd_mode_t RND_BYPASS  = 2'b11;

  // A rounded-up value 2^(K+1) can need one bit beyond the operand width.
  function automatic int data_w(input int width);
    return width + 1;
  endfunction

  // Exponent must hold K+1, which reaches WIDTH for the largest operands.
  function automatic int exp_w(input int log2_width);
    return log2_width + 1;
  endfunction

endpackage

// File: rtl/pow2_round_lane.sv
// Combinational per-lane analysis: leading-one position K, the bit just
// below it (decision), the OR of everything further down (sticky), and zero.
module pow2_round_lane #(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4
) (
  input  logic [WIDTH-1:0]      a_i,
  output logic [LOG2_WIDTH-1:0] k_o,
  output logic                  decision_o,
  output logic                  sticky_o,
  output logic                  zero_o
);

  // Ascending scan: the last set bit seen is the leading one.
  always_comb begin
    k_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a_i[i]) k_o = LOG2_WIDTH'(i);
    end
  end

  always_comb begin
    decision_o = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (k_o == LOG2_WIDTH'(i)) decision_o = a_i[i-1];
    end
  end

  always_comb begin
    sticky_o = 1'b0;
    for (int j = 0; j < WIDTH - 2; j++) begin
      if (LOG2_WIDTH'(j + 2) <= k_o) sticky_o = sticky_o | a_i[j];
    end
  end

  assign zero_o = ~|a_i;

endmodule

// File: rtl/pow2_round_pipe.sv
// Two-stage multi-lane power-of-two rounder with valid/ready on both sides.
// Define RND_TIE_EVEN_EN to make nearest-mode ties pick the even exponent.
module pow2_round_pipe
  import rnd_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4,
  parameter int LANES      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [1:0]                            in_mode,
  input  logic [LANES*WIDTH-1:0]                in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LANES*data_w(WIDTH)-1:0]        out_data,
  output logic [LANES*exp_w(LOG2_WIDTH)-1:0]    out_exp,
  output logic [LANES-1:0]                      out_zero
);

  localparam int DW = data_w(WIDTH);
  localparam int EW = exp_w(LOG2_WIDTH);

  logic [LANES-1:0][LOG2_WIDTH-1:0] lane_k;
  logic [LANES-1:0]                 lane_dec;
  logic [LANES-1:0]                 lane_sticky;
  logic [LANES-1:0]                 lane_zero;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pow2_round_lane #(
      .WIDTH      (WIDTH),
      .LOG2_WIDTH (LOG2_WIDTH)
    ) u_lane (
      .a_i        (in_data[g*WIDTH +: WIDTH]),
      .k_o        (lane_k[g]),
      .decision_o (lane_dec[g]),
      .sticky_o   (lane_sticky[g]),
      .zero_o     (lane_zero[g])
    );
  end

  logic                             s1_valid_q, s1_valid_d;
  rnd_mode_t                        s1_mode_q;
  logic [LANES-1:0][WIDTH-1:0]      s1_a_q;
  logic [LANES-1:0][LOG2_WIDTH-1:0] s1_k_q;
  logic [LANES-1:0]                 s1_dec_q;
  logic [LANES-1:0]                 s1_sticky_q;
  logic [LANES-1:0]                 s1_zero_q;

  logic                             s2_valid_q, s2_valid_d;
  logic [LANES*DW-1:0]              out_data_q, out_data_d;
  logic [LANES*EW-1:0]              out_exp_q, out_exp_d;
  logic [LANES-1:0]                 out_zero_q, out_zero_d;

  logic s1_load;
  logic s2_load;

  // No skid buffer: in_ready follows out_ready combinationally when both stages are full.
  assign s2_load    = ~s2_valid_q | out_ready;
  assign s1_load    = ~s1_valid_q | s2_load;
  assign in_ready   = s1_load;
  assign s1_valid_d = s1_load ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

  for (genvar g = 0; g < LANES; g++) begin : g_sel
    logic          up;
    logic [DW-1:0] pow_k;
    logic [DW-1:0] lane_data;
    logic [EW-1:0] lane_exp;

    always_comb begin
      up = 1'b0;
      case (s1_mode_q)
`ifdef RND_TIE_EVEN_EN
        // A tie (decision without sticky) goes up only if K+1 is the even exponent.
        RND_NEAREST: up = s1_dec_q[g] & (s1_sticky_q[g] | s1_k_q[g][0]);
`else
        RND_NEAREST: up = s1_dec_q[g];
`endif
        RND_CEIL:    up = s1_dec_q[g] | s1_sticky_q[g];
        default:     up = 1'b0;
      endcase
    end

    assign pow_k = DW'(1) << s1_k_q[g];

    always_comb begin
      lane_data = '0;
      lane_exp  = '0;
      if (s1_zero_q[g]) begin
        lane_data = '0;
        lane_exp  = '0;
      end else if (s1_mode_q == RND_BYPASS) begin
        lane_data = {1'b0, s1_a_q[g]};
        lane_exp  = EW'(s1_k_q[g]);
      end else begin
        lane_data = up ? (pow_k << 1) : pow_k;
        lane_exp  = EW'(s1_k_q[g]) + EW'(up);
      end
    end

    assign out_data_d[g*DW +: DW] = lane_data;
    assign out_exp_d[g*EW +: EW]  = lane_exp;
    assign out_zero_d[g]          = s1_zero_q[g];
  end

  // Payload registers load only with a real beat so idle-time garbage never reaches S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= RND_NEAREST;
      s1_a_q      <= '0;
      s1_k_q      <= '0;
      s1_dec_q    <= '0;
      s1_sticky_q <= '0;
      s1_zero_q   <= '0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load && in_valid) begin
        s1_mode_q   <= in_mode;
        s1_a_q      <= in_data;
        s1_k_q      <= lane_k;
        s1_dec_q    <= lane_dec;
        s1_sticky_q <= lane_sticky;
        s1_zero_q   <= lane_zero;
      end
      if (s2_load && s1_valid_q) begin
        out_data_q <= out_data_d;
        out_exp_q  <= out_exp_d;
        out_zero_q <= out_zero_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;

endmodule
